rsa_stream_ctrl: RTL

// Transmit-side controller for the RSA systolic array: drives the Xin/Yin operand

---
 rtl/rsa_stream_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rsa_stream_ctrl.sv
// Transmit-side controller for the RSA systolic array: streams X/Y operands from the
// operand buffers, fires SA_start, then pops X*Y results and hands them to the host.
module rsa_stream_ctrl #(
    parameter int X         = 3,
    parameter int N         = 3,
    parameter int Y         = 3,
    parameter int IN_LEN    = 4,
    parameter int OUT_LEN   = 8,
    parameter int MEM_AW    = 4,
    parameter int START_GAP = 2,
    parameter int DRAIN_DLY = 13
) (
    input  logic               clk,
    input  logic               sys_rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               x_rd_en,
    output logic [MEM_AW-1:0]  x_rd_addr,
    input  logic [IN_LEN-1:0]  x_rd_data,
    output logic               y_rd_en,
    output logic [MEM_AW-1:0]  y_rd_addr,
    input  logic [IN_LEN-1:0]  y_rd_data,
    output logic               Xin_val,
    output logic [IN_LEN-1:0]  Xin_data,
    output logic               Yin_val,
    output logic [IN_LEN-1:0]  Yin_data,
    output logic               SA_start,
    output logic               out_rdy,
    input  logic [OUT_LEN-1:0] out_data,
    output logic               res_val,
    output logic [OUT_LEN-1:0] res_data,
    output logic [MEM_AW-1:0]  res_idx
);
    localparam int XN    = X * N;
    localparam int YN    = Y * N;
    localparam int XY    = X * Y;
    localparam int LMAX  = (XN > YN) ? XN : YN;
    localparam int CMAX0 = (LMAX > XY) ? LMAX : XY;
    localparam int CMAX1 = (CMAX0 > DRAIN_DLY) ? CMAX0 : DRAIN_DLY;
    localparam int CMAX  = (CMAX1 > START_GAP + 1) ? CMAX1 : START_GAP + 1;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_XN        = CW'(XN);
    localparam logic [CW-1:0] C_YN        = CW'(YN);
    localparam logic [CW-1:0] C_XY        = CW'(XY);
    localparam logic [CW-1:0] C_LMAX      = CW'(LMAX);
    localparam logic [CW-1:0] C_GAP       = CW'(START_GAP);
    localparam logic [CW-1:0] C_WAIT_LAST = CW'((DRAIN_DLY >= 2) ? DRAIN_DLY - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_FIRE, S_WAIT, S_DRAIN, S_FLUSH
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic                r_pop_d;
    logic [MEM_AW-1:0]   r_res_cnt;
    logic [CW-1:0]       w_cnt_inc;

    assign w_cnt_inc = r_cnt + 1'b1;

    // Buffer read data is already registered; gate it so idle streams read as zero.
    assign Xin_data = Xin_val ? x_rd_data : '0;
    assign Yin_data = Yin_val ? y_rd_data : '0;

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pop_d   <= 1'b0;
            r_res_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_rd_en   <= 1'b0;
            x_rd_addr <= '0;
            y_rd_en   <= 1'b0;
            y_rd_addr <= '0;
            Xin_val   <= 1'b0;
            Yin_val   <= 1'b0;
            SA_start  <= 1'b0;
            out_rdy   <= 1'b0;
            res_val   <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
        end else begin
            Xin_val  <= x_rd_en;
            Yin_val  <= y_rd_en;
            r_pop_d  <= out_rdy;
            res_val  <= r_pop_d;
            SA_start <= 1'b0;
            done     <= 1'b0;
            if (r_pop_d) begin
                res_data  <= out_data;
                res_idx   <= r_res_cnt;
                r_res_cnt <= r_res_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        busy      <= 1'b1;
                        r_cnt     <= '0;
                        x_rd_en   <= 1'b1;
                        x_rd_addr <= '0;
                        y_rd_en   <= 1'b1;
                        y_rd_addr <= '0;
                        res_idx   <= '0;
                        r_res_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    // The shorter stream parks its address at 0 once exhausted.
                    x_rd_en   <= (w_cnt_inc < C_XN);
                    x_rd_addr <= (w_cnt_inc < C_XN) ? MEM_AW'(w_cnt_inc) : '0;
                    y_rd_en   <= (w_cnt_inc < C_YN);
                    y_rd_addr <= (w_cnt_inc < C_YN) ? MEM_AW'(w_cnt_inc) : '0;
                    if (w_cnt_inc == C_LMAX) begin
                        r_state <= S_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_GAP: begin
                    // First GAP cycle still carries the last beat; then START_GAP idle cycles.
                    if (r_cnt == C_GAP) begin
                        r_state  <= S_FIRE;
                        SA_start <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_FIRE: begin
                    r_cnt <= '0;
                    if (DRAIN_DLY <= 1) begin
                        r_state <= S_DRAIN;
                        out_rdy <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == C_WAIT_LAST) begin
                        r_state <= S_DRAIN;
                        out_rdy <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_DRAIN: begin
                    if (w_cnt_inc == C_XY) begin
                        out_rdy <= 1'b0;
                        r_state <= S_FLUSH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_FLUSH: begin
                    // Cycle 0 captures the last pop; cycle 1 shows it with done.
                    if (r_cnt == '0) begin
                        done  <= 1'b1;
                        r_cnt <= w_cnt_inc;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
